// File: rtl/overlay_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// overlay_pkg: shared scheduler states and coordinate constants
// Revision: 1.0
// ----------------------------------------------------------------------
package overlay_pkg;

  localparam int COORD_W = 13;

  localparam logic [COORD_W-1:0] X_MAX_DEF = 13'd639;
  localparam logic [COORD_W-1:0] Y_MAX_DEF = 13'd479;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/marker_hold_timer.sv
`default_nettype none
// ----------------------------------------------------------------------
// marker_hold_timer: keeps the overlay marker lit for HOLD_FRAMES frames
// Revision: 1.0
// ----------------------------------------------------------------------
module marker_hold_timer #(
  parameter int HOLD_FRAMES = 30
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic frame_tick_i,
  input  logic commit_i,
  input  logic commit_valid_i,
  output logic finished_o
);
  import overlay_pkg::*;

  localparam int HC_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HC_W-1:0] HC_RELOAD = HC_W'(HOLD_FRAMES - 1);
  localparam logic [HC_W-1:0] HC_ONE    = HC_W'(1);

  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            finished_q, finished_d;

  // The commit frame itself counts as the first visible frame, hence the -1 reload.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    finished_d = finished_q;
    if (frame_tick_i) begin
      if (commit_i) begin
        finished_d = commit_valid_i;
        hold_cnt_d = commit_valid_i ? HC_RELOAD : '0;
      end else if (hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - HC_ONE;
      end else begin
        finished_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= '0;
      finished_q <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      finished_q <= finished_d;
    end
  end

  assign finished_o = finished_q;

endmodule
`default_nettype wire

// File: rtl/marker_result_sched.sv
`default_nettype none
// ----------------------------------------------------------------------
// marker_result_sched: starts the position search once per frame and
// double-buffers its result for the overlay.   Revision: 1.0
// ----------------------------------------------------------------------
module marker_result_sched #(
  parameter int                 COORD_W        = overlay_pkg::COORD_W,
  parameter logic [COORD_W-1:0] X_MAX          = COORD_W'(overlay_pkg::X_MAX_DEF),
  parameter logic [COORD_W-1:0] Y_MAX          = COORD_W'(overlay_pkg::Y_MAX_DEF),
  parameter int                 HOLD_FRAMES    = 30,
  parameter int                 TIMEOUT_FRAMES = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEnable,
  input  logic               iFrameStart,
  input  logic               iDone,
  input  logic [COORD_W-1:0] iXres,
  input  logic [COORD_W-1:0] iYres,
  input  logic               iFound,
  output logic               oStart,
  output logic               oAbort,
  output logic [COORD_W-1:0] oXresult,
  output logic [COORD_W-1:0] oYresult,
  output logic               oFinished,
  output logic [7:0]         oTimeoutCnt,
  output logic               oBusy
);
  import overlay_pkg::*;

  localparam int FC_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(TIMEOUT_FRAMES);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

  sched_state_e       state_q, state_d;
  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [COORD_W-1:0] shadow_x_q, shadow_x_d;
  logic [COORD_W-1:0] shadow_y_q, shadow_y_d;
  logic               shadow_v_q, shadow_v_d;
  logic               pend_q, pend_d;
  logic               start_q, start_d;
  logic               abort_q, abort_d;
  logic               busy_q;
  logic [7:0]         tmo_q, tmo_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  logic collide;
  logic frame_tick;
  logic commit;

  // A done landing on a frame start swallows that frame start entirely.
  assign collide    = (state_q == RUN) && iDone && iFrameStart;
  assign frame_tick = iFrameStart && !collide;
  assign commit     = frame_tick && pend_q && iEnable;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    shadow_x_d  = shadow_x_q;
    shadow_y_d  = shadow_y_q;
    shadow_v_d  = shadow_v_q;
    pend_d      = pend_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    tmo_d       = tmo_q;
    x_d         = x_q;
    y_d         = y_q;

    if (commit) begin
      pend_d = 1'b0;
      if (shadow_v_q) begin
        x_d = shadow_x_q;
        y_d = shadow_y_q;
      end
    end

    if (!iEnable) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      abort_d = (state_q == RUN);
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (iFrameStart) begin
            start_d     = 1'b1;
            frame_cnt_d = '0;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (iDone) begin
            shadow_x_d = iXres;
            shadow_y_d = iYres;
            shadow_v_d = iFound && (iXres <= X_MAX) && (iYres <= Y_MAX);
            pend_d     = 1'b1;
            state_d    = ARM;
          end else if (iFrameStart) begin
            frame_cnt_d = frame_cnt_q + FC_ONE;
            if (frame_cnt_d == FC_LAST) begin
              abort_d = 1'b1;
              tmo_d   = (tmo_q == 8'd255) ? tmo_q : tmo_q + 8'd1;
              state_d = ARM;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      shadow_x_q  <= '0;
      shadow_y_q  <= '0;
      shadow_v_q  <= 1'b0;
      pend_q      <= 1'b0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 8'd0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      shadow_x_q  <= shadow_x_d;
      shadow_y_q  <= shadow_y_d;
      shadow_v_q  <= shadow_v_d;
      pend_q      <= pend_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      busy_q      <= (state_d == RUN);
      tmo_q       <= tmo_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  marker_hold_timer #(
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_hold (
    .clk_i          (iCLK),
    .rst_ni         (iRST),
    .frame_tick_i   (frame_tick),
    .commit_i       (commit),
    .commit_valid_i (shadow_v_q),
    .finished_o     (oFinished)
  );

  assign oStart      = start_q;
  assign oAbort      = abort_q;
  assign oXresult    = x_q;
  assign oYresult    = y_q;
  assign oTimeoutCnt = tmo_q;
  assign oBusy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_marker_result_sched.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_marker_result_sched: directed plan plus randomized traffic against
// a frame-level reference model.   Revision: 1.0
// ----------------------------------------------------------------------
module tb_marker_result_sched;

  localparam int HOLD = 3;
  localparam int TMO  = 4;

  logic        clk;
  logic        rst_n;
  logic        en, fs, dn, fnd;
  logic [12:0] xr, yr;
  logic        o_start, o_abort, o_fin, o_busy;
  logic [12:0] o_x, o_y;
  logic [7:0]  o_tmo;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: mode 0=idle 1=armed 2=running
  int          m_mode, m_frames, m_left, m_tmo;
  bit          m_pend, m_sv;
  logic [12:0] m_sx, m_sy;
  logic [12:0] e_x, e_y;
  bit          e_start, e_abort;

  marker_result_sched #(
    .HOLD_FRAMES    (HOLD),
    .TIMEOUT_FRAMES (TMO)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst_n),
    .iEnable     (en),
    .iFrameStart (fs),
    .iDone       (dn),
    .iXres       (xr),
    .iYres       (yr),
    .iFound      (fnd),
    .oStart      (o_start),
    .oAbort      (o_abort),
    .oXresult    (o_x),
    .oYresult    (o_y),
    .oFinished   (o_fin),
    .oTimeoutCnt (o_tmo),
    .oBusy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step(input bit e, input bit f, input bit d,
                            input logic [12:0] x, input logic [12:0] y, input bit k);
    bit swallowed;
    swallowed = (m_mode == 2) && d && f;
    e_start = 1'b0;
    e_abort = 1'b0;
    if (f && !swallowed) begin
      if (m_pend && e) begin
        if (m_sv) begin
          e_x = m_sx; e_y = m_sy; m_left = HOLD;
        end else begin
          m_left = 0;
        end
        m_pend = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    if (!e) begin
      if (m_mode == 2) e_abort = 1'b1;
      m_mode = 0;
      m_pend = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (f) begin
        e_start = 1'b1; m_frames = 0; m_mode = 2;
      end
    end else begin
      if (d) begin
        m_sx = x; m_sy = y;
        m_sv = k && (x <= 13'd639) && (y <= 13'd479);
        m_pend = 1'b1;
        m_mode = 1;
      end else if (f) begin
        m_frames++;
        if (m_frames >= TMO) begin
          e_abort = 1'b1;
          if (m_tmo < 255) m_tmo++;
          m_mode = 1;
        end
      end
    end
  endtask

  task automatic step(input bit e, input bit f, input bit d,
                      input logic [12:0] x, input logic [12:0] y, input bit k);
    @(negedge clk);
    en = e; fs = f; dn = d; xr = x; yr = y; fnd = k;
    model_step(e, f, d, x, y, k);
    @(posedge clk);
    #1;
    check("start",    o_start, e_start);
    check("abort",    o_abort, e_abort);
    check("xresult",  o_x,     e_x);
    check("yresult",  o_y,     e_y);
    check("finished", o_fin,   m_left > 0);
    check("tmo_cnt",  o_tmo,   m_tmo);
    check("busy",     o_busy,  m_mode == 2);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 13'd0, 13'd0, 1'b0);
  endtask

  task automatic frame();
    step(1'b1, 1'b1, 1'b0, 13'd0, 13'd0, 1'b0);
  endtask

  initial begin
    int fs_cd, off_cd;
    bit  r_f, r_d, r_e;
    m_mode = 0; m_frames = 0; m_left = 0; m_tmo = 0;
    m_pend = 1'b0; m_sv = 1'b0; m_sx = '0; m_sy = '0;
    e_x = '0; e_y = '0; e_start = 1'b0; e_abort = 1'b0;
    rst_n = 1'b0; en = 1'b0; fs = 1'b0; dn = 1'b0; xr = '0; yr = '0; fnd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", o_start, 0);
    check("rst_abort", o_abort, 0);
    check("rst_x",     o_x,     0);
    check("rst_y",     o_y,     0);
    check("rst_fin",   o_fin,   0);
    check("rst_tmo",   o_tmo,   0);
    check("rst_busy",  o_busy,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // enable, frame start on the 10th cycle after release
    quiet(9);
    frame();
    check("plan_start_pulse", o_start, 1);
    check("plan_busy",        o_busy,  1);
    quiet(1);
    check("plan_start_once",  o_start, 0);

    // valid result mid-frame, committed on the next frame start
    quiet(3);
    step(1'b1, 1'b0, 1'b1, 13'd100, 13'd50, 1'b1);
    quiet(3);
    check("plan_x_held", o_x, 0);
    frame();
    check("plan_x_commit", o_x,   100);
    check("plan_y_commit", o_y,   50);
    check("plan_fin_on",   o_fin, 1);

    // no further done: marker holds three frames, then timeout
    quiet(4); frame();
    quiet(4); frame();
    check("plan_fin_hold", o_fin, 1);
    quiet(4); frame();
    check("plan_fin_drop", o_fin, 0);
    quiet(4); frame();
    check("plan_timeout_abort", o_abort, 1);
    check("plan_timeout_cnt",   o_tmo,   1);
    check("plan_timeout_nostart", o_start, 0);
    quiet(4); frame();
    check("plan_restart", o_start, 1);

    // valid commit, then out-of-range X clears the marker
    step(1'b1, 1'b0, 1'b1, 13'd200, 13'd60, 1'b1);
    quiet(2); frame();
    check("plan_x_200", o_x, 200);
    step(1'b1, 1'b0, 1'b1, 13'd700, 13'd10, 1'b1);
    quiet(2); frame();
    check("plan_bad_fin", o_fin, 0);
    check("plan_bad_x",   o_x,   200);

    // done on a frame start: nothing commits or starts until the next frame
    quiet(2);
    step(1'b1, 1'b1, 1'b1, 13'd5, 13'd6, 1'b1);
    check("plan_coll_nostart", o_start, 0);
    check("plan_coll_x",       o_x,     200);
    quiet(3); frame();
    check("plan_coll_commit", o_x, 5);
    quiet(2);
    step(1'b0, 1'b0, 1'b0, 13'd0, 13'd0, 1'b0);
    check("plan_dis_abort", o_abort, 1);
    check("plan_dis_busy",  o_busy,  0);
    step(1'b0, 1'b1, 1'b0, 13'd0, 13'd0, 1'b0);
    check("plan_dis_nostart", o_start, 0);

    // randomized traffic
    fs_cd = 5; off_cd = 0;
    for (int c = 0; c < 4000; c++) begin
      r_f = (fs_cd == 0);
      fs_cd = r_f ? int'($urandom_range(4, 10)) : fs_cd - 1;
      if (off_cd > 0) off_cd--;
      else if (!r_f && $urandom_range(0, 79) == 0) off_cd = $urandom_range(1, 6);
      r_e = (off_cd == 0) || r_f;
      if (r_f) off_cd = 0;
      r_d = ($urandom_range(0, 11) == 0);
      step(r_e, r_f, r_d, 13'($urandom_range(0, 800)), 13'($urandom_range(0, 600)),
           $urandom_range(0, 4) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/marker_result_sched.md
Name: marker_result_sched

Overview:
- Sequences the per-frame position-search engine and feeds its result to the grayscale/marker overlay stage.
- Issues one start per frame and waits for done, with a frame-count timeout.
- Double-buffers the result coordinates so the overlay only changes at a frame boundary, and keeps the marker visible for a bounded number of frames.
- Sits between the CCD frame timing logic, the search engine and the overlay block.

Parameters:
- COORD_W, 13, width of all coordinate ports.
- X_MAX, 13'd639, largest legal result X; anything above it is an invalid result.
- Y_MAX, 13'd479, largest legal result Y; anything above it is an invalid result.
- HOLD_FRAMES, 30, number of frame starts the marker stays visible after a valid commit (must be at least 1).
- TIMEOUT_FRAMES, 4, number of frame starts in RUN without done before the run is abandoned (must be at least 1).

Ports:
- iCLK  in  1  pixel/system clock.
- iRST  in  1  asynchronous reset, active low.
- iEnable  in  1  scheduler enable, level.
- iFrameStart  in  1  one-cycle pulse at the start of each frame.
- iDone  in  1  one-cycle pulse from the engine; the result is valid that cycle.
- iXres  in  COORD_W  engine result X.
- iYres  in  COORD_W  engine result Y.
- iFound  in  1  engine found a target, qualified by iDone.
- oStart  out  1  one-cycle engine start pulse.
- oAbort  out  1  one-cycle engine abort pulse.
- oXresult  out  COORD_W  committed X to the overlay.
- oYresult  out  COORD_W  committed Y to the overlay.
- oFinished  out  1  marker enable to the overlay.
- oTimeoutCnt  out  8  saturating count of timeouts.
- oBusy  out  1  high in RUN.

Behaviour:
- Reset (iRST=0, asynchronous): state IDLE; all outputs 0; shadow registers, pend, hold_cnt and frame_cnt cleared.
- All outputs are registered.
- FSM IDLE: when iEnable=1, go to ARM next cycle.
- FSM ARM: when iFrameStart=1, oStart=1 for exactly the following cycle; frame_cnt cleared; go to RUN.
- FSM RUN, iDone=1:
  - shadow_x/y <= iXres/iYres.
  - shadow_v <= iFound && iXres<=X_MAX && iYres<=Y_MAX.
  - pend <= 1; go to ARM.
- FSM RUN, iFrameStart=1 with no iDone:
  - frame_cnt++.
  - When frame_cnt reaches TIMEOUT_FRAMES: oAbort pulses for 1 cycle, oTimeoutCnt increments (saturates at 255), go to ARM.
  - The frame start that causes the timeout does not also issue oStart; the next frame start does.
- iDone and iFrameStart in the same RUN cycle: iDone wins and frame_cnt is unchanged. That frame start neither commits the new result nor starts the engine; both happen at the next frame start.
- iDone outside RUN: ignored.
- iEnable=0 in any state: go to IDLE next cycle and clear pend. If the state was RUN, pulse oAbort. A pending oStart is suppressed.
- Commit, evaluated on every iFrameStart in every state including IDLE (except the RUN-iDone collision above):
  - pend=1, shadow_v=1: oXresult/oYresult <= shadow; oFinished <= 1; hold_cnt <= HOLD_FRAMES-1; pend <= 0.
  - pend=1, shadow_v=0: oFinished <= 0; hold_cnt <= 0; coordinates retained; pend <= 0.
  - pend=0, hold_cnt>0: hold_cnt--.
  - pend=0, hold_cnt=0: oFinished <= 0.
  - Net effect: a valid commit stays visible for exactly HOLD_FRAMES frames unless a new commit replaces it.
- oXresult, oYresult and oFinished never change except in the cycle following an iFrameStart, so there is no tearing.
- Latency: iFrameStart to oStart is 1 cycle; iFrameStart to committed outputs is 1 cycle.
- oBusy = (state==RUN).

Decomposition:
- Shared package (overlay_pkg): state enum {IDLE, ARM, RUN}, COORD_W, and default X_MAX/Y_MAX constants, shared with the overlay and save-params logic.
- One natural sub-module: marker_hold_timer. It owns hold_cnt and oFinished; its inputs are the frame-start pulse, a commit strobe and the commit-valid flag.

Test Plan:
- Reset release, iEnable=1, frame start at cycle 10 -> oStart high at cycle 11 only; oBusy=1 from cycle 11.
- iDone with X=100, Y=50, iFound=1 mid-frame -> outputs unchanged until the next frame start, then oXresult=100, oYresult=50, oFinished=1 one cycle later.
- HOLD_FRAMES=3, one valid commit, then engine never found -> oFinished stays 1 for 3 frames and drops on the 4th frame start.
- iDone with X=700 (>X_MAX), iFound=1 -> commit clears oFinished; coordinates keep their previous values.
- TIMEOUT_FRAMES=4 with no iDone -> oAbort pulse after the 4th frame start in RUN, oTimeoutCnt=1, new oStart on the following frame start.
- iDone and iFrameStart in the same cycle, then iEnable=0 mid-RUN -> commit deferred one frame; oAbort pulses once; state IDLE; pend cleared; no oStart.
